// File: rtl/jt6295_mix_if.sv
// jt6295_mix_if
//   Slot bus between the per-channel ADPCM decoder and the 4-channel mixer.
//   The decoder side (master) presents one channel slot per cen pulse. The
//   mixer side (slave) returns the mixed sample and its update strobe.
// Signals
//   cen     decoder slot enable, one slot per pulse
//   ch      channel index of the current slot (0..3)
//   en      channel playing; low forces zero gain
//   att     4-bit attenuation code of channel ch
//   snd     signed 12-bit decoded sample of channel ch
//   sound   signed OUTW-bit mixed sample, held between rounds
//   sample  one-clk pulse when sound updates
interface jt6295_mix_if #(
    parameter int OUTW = 14
);
    logic                   cen;
    logic [1:0]             ch;
    logic                   en;
    logic [3:0]             att;
    logic signed [11:0]     snd;
    logic signed [OUTW-1:0] sound;
    logic                   sample;

    modport master (
        output cen, ch, en, att, snd,
        input  sound, sample
    );

    modport slave (
        input  cen, ch, en, att, snd,
        output sound, sample
    );
endinterface

// File: rtl/jt6295_mix.sv
// jt6295_mix
//   Applies the OKI volume table to each time-multiplexed channel sample and
//   sums the four channels into one signed mixed sample. Three cen-qualified
//   stages: gain lookup, multiply, accumulate/output.
// Ports
//   clk     system clock
//   rst_n   asynchronous reset, active low
//   bus     jt6295_mix_if slave: cen/ch/en/att/snd in, sound/sample out
// Parameter
//   OUTW    mixed output width (12..16); below 14 saturates, 14 and above
//           sign-extends the 15-bit internal sum
module jt6295_mix #(
    parameter int OUTW = 14
) (
    input  logic         clk,
    input  logic         rst_n,
    jt6295_mix_if.slave  bus
);
    localparam logic signed [16:0] SMAX = 17'((1 << (OUTW - 1)) - 1);
    localparam logic signed [16:0] SMIN = 17'(-(1 << (OUTW - 1)));

    // Volume table, gain in units of 1/32.
    function automatic logic [5:0] gain_lut(input logic [3:0] code);
        logic [5:0] g;
        case (code)
            4'd0:    g = 6'd32;
            4'd1:    g = 6'd22;
            4'd2:    g = 6'd16;
            4'd3:    g = 6'd11;
            4'd4:    g = 6'd8;
            4'd5:    g = 6'd6;
            4'd6:    g = 6'd4;
            4'd7:    g = 6'd3;
            4'd8:    g = 6'd2;
            default: g = 6'd0;
        endcase
        return g;
    endfunction

    // Fit the 15-bit sum into the output width.
    function automatic logic signed [OUTW-1:0] fit(input logic signed [14:0] v);
        logic signed [16:0]     w;
        logic signed [OUTW-1:0] r;
        w = 17'(v);
        if (OUTW < 14 && w > SMAX) begin
            r = SMAX[OUTW-1:0];
        end else if (OUTW < 14 && w < SMIN) begin
            r = SMIN[OUTW-1:0];
        end else begin
            r = w[OUTW-1:0];
        end
        return r;
    endfunction

    logic signed [11:0] snd_p0;
    logic        [5:0]  gain_p0;
    logic        [1:0]  ch_p0;
    logic signed [17:0] prod_p1;
    logic        [1:0]  ch_p1;
    logic signed [14:0] acc_p2;

    logic signed [12:0] term;
    logic signed [14:0] acc_sum;

    // Floor division by 32 via arithmetic shift; the sum of four 13-bit
    // terms always fits in 15 bits.
    always_comb begin
        term    = 13'(prod_p1 >>> 5);
        acc_sum = acc_p2 + 15'(term);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snd_p0     <= '0;
            gain_p0    <= '0;
            ch_p0      <= '0;
            prod_p1    <= '0;
            ch_p1      <= '0;
            acc_p2     <= '0;
            bus.sound  <= '0;
            bus.sample <= 1'b0;
        end else begin
            bus.sample <= 1'b0;
            if (bus.cen) begin
                // stage p0: capture sample, look up gain
                snd_p0  <= bus.snd;
                gain_p0 <= bus.en ? gain_lut(bus.att) : 6'd0;
                ch_p0   <= bus.ch;
                // stage p1: signed multiply, gain treated as unsigned
                prod_p1 <= 18'(snd_p0) * 18'($signed({1'b0, gain_p0}));
                ch_p1   <= ch_p0;
                // stage p2: accumulate; ch0 restarts the round
                if (ch_p1 == 2'd0) begin
                    acc_p2 <= 15'(term);
                end else begin
                    acc_p2 <= acc_sum;
                end
                if (ch_p1 == 2'd3) begin
                    bus.sound  <= fit(acc_sum);
                    bus.sample <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_jt6295_mix.sv
module tb_jt6295_mix;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic               cen = 1'b0;
    logic [1:0]         ch  = '0;
    logic               en  = 1'b0;
    logic [3:0]         att = '0;
    logic signed [11:0] snd = '0;

    jt6295_mix_if #(.OUTW(14)) b14();
    jt6295_mix_if #(.OUTW(12)) b12();

    assign b14.cen = cen;  assign b12.cen = cen;
    assign b14.ch  = ch;   assign b12.ch  = ch;
    assign b14.en  = en;   assign b12.en  = en;
    assign b14.att = att;  assign b12.att = att;
    assign b14.snd = snd;  assign b12.snd = snd;

    jt6295_mix #(.OUTW(14)) dut14 (.clk(clk), .rst_n(rst_n), .bus(b14));
    jt6295_mix #(.OUTW(12)) dut12 (.clk(clk), .rst_n(rst_n), .bus(b12));

    int tests = 0;
    int fails = 0;
    int q14[$];
    int q12[$];

    typedef struct {
        int       s[4];
        int       a[4];
        bit [3:0] e;
        int       e14;
        int       e12;
    } row_t;

    row_t rows[9];

    int gtab[16] = '{32, 22, 16, 11, 8, 6, 4, 3, 2, 0, 0, 0, 0, 0, 0, 0};

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int term_of(input int s, input int a, input bit e);
        int p;
        p = s * (e ? gtab[a] : 0);
        if (p >= 0) return p / 32;
        return -((-p + 31) / 32);
    endfunction

    function automatic int sat12(input int v);
        if (v > 2047) return 2047;
        if (v < -2048) return -2048;
        return v;
    endfunction

    function automatic row_t mk(input int s0, input int s1, input int s2, input int s3,
                                input int a0, input int a1, input int a2, input int a3,
                                input bit [3:0] e, input int e14, input int e12);
        row_t r;
        r.s[0] = s0; r.s[1] = s1; r.s[2] = s2; r.s[3] = s3;
        r.a[0] = a0; r.a[1] = a1; r.a[2] = a2; r.a[3] = a3;
        r.e = e; r.e14 = e14; r.e12 = e12;
        return r;
    endfunction

    // Scoreboard consumers: one per DUT, compared on each strobe.
    always @(negedge clk) begin
        if (b14.sample) begin
            if (q14.size() == 0) chk("strobe14_unexpected", int'($signed(b14.sound)), 99999);
            else chk("sound14", int'($signed(b14.sound)), q14.pop_front());
        end
        if (b12.sample) begin
            if (q12.size() == 0) chk("strobe12_unexpected", int'($signed(b12.sound)), 99999);
            else chk("sound12", int'($signed(b12.sound)), q12.pop_front());
        end
    end

    task automatic slot(input int c, input bit e, input int a, input int s);
        @(negedge clk);
        ch  = 2'(c);
        en  = e;
        att = 4'(a);
        snd = 12'(s);
        cen = 1'b1;
        @(negedge clk);
        cen = 1'b0;
    endtask

    task automatic run_row(input row_t r);
        for (int c = 0; c < 4; c++) begin
            if (c == 3) begin
                q14.push_back(r.e14);
                q12.push_back(r.e12);
            end
            slot(c, r.e[c], r.a[c], r.s[c]);
        end
    endtask

    task automatic flush();
        slot(0, 1'b0, 0, 0);
        slot(0, 1'b0, 0, 0);
    endtask

    initial begin
        row_t r;
        int   sum;
        int   snap;
        bit   bad;

        rows[0] = mk(100, 100, 100, 100, 0, 0, 0, 0, 4'b1111, 400, 400);
        rows[1] = mk(-2048, -2048, -2048, -2048, 2, 2, 2, 2, 4'b1111, -4096, -2048);
        rows[2] = mk(-1, -1, -1, -1, 1, 1, 1, 1, 4'b1111, -4, -4);
        rows[3] = mk(2047, 2047, 2047, 2047, 0, 0, 0, 0, 4'b1111, 8188, 2047);
        rows[4] = mk(-2048, -2048, -2048, -2048, 0, 0, 0, 0, 4'b1111, -8192, -2048);
        rows[5] = mk(1000, 2000, 320, -64, 9, 0, 8, 4, 4'b1101, 4, 4);
        rows[6] = mk(500, -500, 7, -7, 3, 5, 6, 7, 4'b1111, 76, 76);
        rows[7] = mk(2047, 2047, 2047, 2047, 1, 1, 1, 1, 4'b1111, 5628, 2047);
        rows[8] = mk(2047, -2048, -2048, -100, 15, 12, 0, 1, 4'b1011, -69, -69);

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_sound14", int'($signed(b14.sound)), 0);
        chk("reset_sample14", int'(b14.sample), 0);
        chk("reset_sound12", int'($signed(b12.sound)), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven rounds, back to back
        for (int i = 0; i < 9; i++) run_row(rows[i]);
        flush();

        // Random rounds against the behavioural model
        for (int k = 0; k < 8; k++) begin
            sum = 0;
            for (int c = 0; c < 4; c++) begin
                r.s[c] = int'($urandom_range(0, 4095)) - 2048;
                r.a[c] = int'($urandom_range(0, 15));
                r.e[c] = ($urandom_range(0, 3) != 0);
                sum += term_of(r.s[c], r.a[c], r.e[c]);
            end
            r.e14 = sum;
            r.e12 = sat12(sum);
            run_row(r);
        end
        flush();

        // Stall mid-round: cen low for 50 clocks
        slot(0, 1'b1, 3, 500);
        slot(1, 1'b1, 5, -500);
        snap = int'($signed(b14.sound));
        bad = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (b14.sample || b12.sample || int'($signed(b14.sound)) != snap) bad = 1'b1;
        end
        chk("stall_quiet", int'(bad), 0);
        q14.push_back(76);
        q12.push_back(76);
        slot(2, 1'b1, 6, 7);
        slot(3, 1'b1, 7, -7);
        flush();

        // Reset mid-round: partial sum discarded, outputs cleared at once
        slot(0, 1'b1, 0, 999);
        slot(1, 1'b1, 0, 999);
        rst_n = 1'b0;
        #1;
        chk("midreset_sound14", int'($signed(b14.sound)), 0);
        chk("midreset_sound12", int'($signed(b12.sound)), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) begin
                q14.push_back(40);
                q12.push_back(40);
            end
            slot(c, 1'b1, 0, 10);
            if (b14.sample || b12.sample) bad = 1'b1;
        end
        chk("no_early_strobe", int'(bad), 0);
        flush();
        repeat (4) @(negedge clk);

        chk("drain14", q14.size(), 0);
        chk("drain12", q12.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
